// File: rtl/axis_frame_source.sv
// Purpose: AXI4-Stream synthetic frame generator (raster order, tuser=SOF, tlast=EOL).
// Latency: first beat valid 1 cycle after accepted start; then 1 beat/cycle at tready=1.
// Backpressure: beats held stable while tvalid && !tready; start ignored unless idle.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : frame request, accepted only when idle
//   cfg_width/height  : frame geometry in beats/lines, latched on accepted start
//   cfg_mode/seed     : pattern select and seed/constant, latched on accepted start
//   busy              : frame in progress (cleared on the frame_done edge)
//   frame_done        : one-cycle completion pulse
//   frame_count       : completed-frame counter (wrapping)
//   m_axis_*          : AXI4-Stream master (tdata, tvalid, tready, tlast, tuser)
module axis_frame_source #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 12,
   parameter int FCNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  cfg_width,
   input  logic [CNT_WIDTH-1:0]  cfg_height,
   input  logic [1:0]            cfg_mode,
   input  logic [DATA_WIDTH-1:0] cfg_seed,
   output logic                  busy,
   output logic                  frame_done,
   output logic [FCNT_WIDTH-1:0] frame_count,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state;
   logic [CNT_WIDTH-1:0]  w_q, h_q;
   logic [1:0]            mode_q;
   logic [DATA_WIDTH-1:0] seed_q;

   // x/y/idx always describe the beat currently sitting in the output registers.
   logic [CNT_WIDTH-1:0]  x, y;
   logic [DATA_WIDTH-1:0] idx;

   logic [CNT_WIDTH-1:0]  w_m1, h_m1;
   logic                  last_x, last_y;
   logic [CNT_WIDTH-1:0]  nx, ny;
   logic [DATA_WIDTH-1:0] nidx;

   function automatic logic [DATA_WIDTH-1:0] pattern(
      input logic [1:0]            mode,
      input logic [DATA_WIDTH-1:0] seed,
      input logic [DATA_WIDTH-1:0] beat,
      input logic [CNT_WIDTH-1:0]  px,
      input logic [CNT_WIDTH-1:0]  py
   );
      logic [DATA_WIDTH-1:0] xe;
      logic [DATA_WIDTH-1:0] ye;
      xe = DATA_WIDTH'(px);
      ye = DATA_WIDTH'(py);
      case (mode)
         2'd0:    return seed + beat;
         2'd1:    return (ye << CNT_WIDTH) | xe;
         2'd2:    return seed;
         default: return xe ^ ye;
      endcase
   endfunction

   // Successor of the beat on the output, so a transfer can reload the
   // output registers on the same edge without a bubble.
   always_comb begin
      w_m1   = w_q - CNT_WIDTH'(1);
      h_m1   = h_q - CNT_WIDTH'(1);
      last_x = (x == w_m1);
      last_y = (y == h_m1);
      nx     = last_x ? '0 : x + CNT_WIDTH'(1);
      ny     = last_x ? y + CNT_WIDTH'(1) : y;
      nidx   = idx + DATA_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         w_q           <= '0;
         h_q           <= '0;
         mode_q        <= '0;
         seed_q        <= '0;
         x             <= '0;
         y             <= '0;
         idx           <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         frame_count   <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  w_q    <= cfg_width;
                  h_q    <= cfg_height;
                  mode_q <= cfg_mode;
                  seed_q <= cfg_seed;
                  busy   <= 1'b1;
                  x      <= '0;
                  y      <= '0;
                  idx    <= '0;
                  if (cfg_width == '0 || cfg_height == '0) begin
                     // Empty frame: nothing is ever presented on the stream.
                     state <= S_DONE;
                  end else begin
                     m_axis_tdata  <= pattern(cfg_mode, cfg_seed, '0, '0, '0);
                     m_axis_tvalid <= 1'b1;
                     m_axis_tuser  <= 1'b1;
                     m_axis_tlast  <= (cfg_width == CNT_WIDTH'(1));
                     state         <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (m_axis_tvalid && m_axis_tready) begin
                  if (last_x && last_y) begin
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     m_axis_tuser  <= 1'b0;
                     state         <= S_DONE;
                  end else begin
                     x             <= nx;
                     y             <= ny;
                     idx           <= nidx;
                     m_axis_tdata  <= pattern(mode_q, seed_q, nidx, nx, ny);
                     m_axis_tlast  <= (nx == w_m1);
                     m_axis_tuser  <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               frame_done  <= 1'b1;
               busy        <= 1'b0;
               frame_count <= frame_count + FCNT_WIDTH'(1);
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_frame_source.sv
// Purpose: randomized scoreboard bench for axis_frame_source.
// Latency: expected beats queued at start; monitor compares every transfer.
// Backpressure: tready optionally randomized; held outputs checked during stalls.
module tb_axis_frame_source;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [11:0] cfg_width = '0;
   logic [11:0] cfg_height = '0;
   logic [1:0]  cfg_mode = '0;
   logic [31:0] cfg_seed = '0;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_count;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        m_axis_tuser;

   axis_frame_source #(.DATA_WIDTH(32), .CNT_WIDTH(12), .FCNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_mode(cfg_mode), .cfg_seed(cfg_seed),
      .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic        l;
      logic        u;
   } beat_t;

   beat_t q[$];
   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int xfer_cnt = 0;
   int last_xfer_cyc = 0;
   int start_cyc = 0;
   int done_cnt = 0;
   int exp_fc = 0;
   bit rdy_rand = 1'b0;
   bit prev_stall = 1'b0;
   logic [34:0] prev_out = '0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   // Reference model: pixel value straight from the pattern definitions.
   function automatic logic [31:0] model_pix(int unsigned mode, int unsigned seed,
                                             int unsigned idx, int unsigned x, int unsigned y);
      case (mode)
         0:       return 32'(seed + idx);
         1:       return 32'(y * 4096 + x);
         2:       return 32'(seed);
         default: return 32'(x ^ y);
      endcase
   endfunction

   task automatic push_frame(input int unsigned w, input int unsigned h,
                             input int unsigned mode, input int unsigned seed);
      int unsigned idx = 0;
      beat_t b;
      for (int unsigned yy = 0; yy < h; yy++) begin
         for (int unsigned xx = 0; xx < w; xx++) begin
            b.d = model_pix(mode, seed, idx, xx, yy);
            b.l = (xx == w - 1);
            b.u = (xx == 0 && yy == 0);
            q.push_back(b);
            idx++;
         end
      end
   endtask

   // Issue a start while the DUT is idle, queue the expected beats, and
   // check first-beat latency and busy.
   task automatic pulse_start(input int unsigned w, input int unsigned h,
                              input int unsigned mode, input int unsigned seed);
      push_frame(w, h, mode, seed);
      cfg_width  = 12'(w);
      cfg_height = 12'(h);
      cfg_mode   = 2'(mode);
      cfg_seed   = seed;
      start      = 1'b1;
      start_cyc  = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      // Scramble config: the latched copy must govern the frame.
      cfg_width  = 12'($urandom_range(1, 9));
      cfg_height = 12'($urandom_range(1, 9));
      cfg_mode   = 2'($urandom);
      cfg_seed   = $urandom;
      chk("busy_after_start", busy, 1);
      chk("tvalid_latency", m_axis_tvalid, (w != 0 && h != 0));
   endtask

   task automatic wait_done(input bit empty_frame);
      bit ok = 1'b0;
      for (int n = 0; n < 4000 && !ok; n++) begin
         @(posedge clk); #1;
         if (frame_done) ok = 1'b1;
      end
      chk("frame_done_seen", ok, 1);
      if (ok) begin
         exp_fc++;
         chk("frame_count", frame_count, 64'(exp_fc));
         chk("busy_at_done", busy, 0);
         chk("beats_remaining", q.size(), 0);
         if (empty_frame) chk("done_latency_empty", cyc - start_cyc, 2);
         else             chk("done_latency", cyc - last_xfer_cyc, 2);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: scoreboard pops on every transfer; stall stability checked.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("hold_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}, prev_out);
         if (m_axis_tvalid && m_axis_tready) begin
            xfer_cnt++;
            last_xfer_cyc = cyc;
            if (q.size() == 0) begin
               chk("unexpected_beat", m_axis_tvalid, 0);
            end else begin
               beat_t b;
               b = q.pop_front();
               chk("tdata", m_axis_tdata, b.d);
               chk("tlast", m_axis_tlast, b.l);
               chk("tuser", m_axis_tuser, b.u);
            end
         end
         if (frame_done) done_cnt++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_out   = {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser};
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int d0;
      bit hit;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_tuser", m_axis_tuser, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_tdata", m_axis_tdata, 0);

      // 4x2 incrementing pattern, continuous ready
      pulse_start(4, 2, 0, 32'h10);
      wait_done(1'b0);

      // 3x2 coordinate pattern
      pulse_start(3, 2, 1, 32'hdead);
      wait_done(1'b0);

      // Same as first frame under random backpressure
      rdy_rand = 1'b1;
      pulse_start(4, 2, 0, 32'h10);
      wait_done(1'b0);

      // Zero-size frames
      pulse_start(0, 5, 0, 32'h1);
      wait_done(1'b1);
      pulse_start(7, 0, 2, 32'h1);
      wait_done(1'b1);

      // Start pulsed mid-frame is ignored
      pulse_start(4, 3, 2, 32'hcafe_f00d);
      repeat (4) @(posedge clk);
      #1;
      cfg_width = 12'd2; cfg_height = 12'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1'b0);
      // Start in the frame_done cycle is accepted immediately
      pulse_start(5, 2, 3, 32'h0);
      wait_done(1'b0);

      // Reset mid-frame
      pulse_start(8, 8, 0, 32'h100);
      base = xfer_cnt;
      hit = 1'b0;
      for (int n = 0; n < 2000 && !hit; n++) begin
         @(posedge clk); #1;
         if (xfer_cnt >= base + 3) hit = 1'b1;
      end
      chk("reached_3_xfers", hit, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      exp_fc = 0;
      chk("midrst_tvalid", m_axis_tvalid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_frame_count", frame_count, 0);
      d0 = done_cnt;
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_no_done", done_cnt, 64'(d0));
      chk("midrst_idle_tvalid", m_axis_tvalid, 0);
      pulse_start(8, 8, 3, 32'h0);
      wait_done(1'b0);

      // Random frames
      for (int i = 0; i < 12; i++) begin
         int unsigned w, h;
         w = $urandom_range(1, 7);
         h = $urandom_range(1, 5);
         pulse_start(w, h, $urandom_range(0, 3), $urandom);
         wait_done(1'b0);
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
AXI4-Stream frame transmitter. It generates one synthetic image frame per start pulse: cfg_width x cfg_height beats in raster order, with tuser marking start-of-frame and tlast marking end-of-line. It drives the slave input of the stream FIFO and downstream rectify pipeline, and is used as a bring-up and test source. The output stage is fully registered and sustains one beat per cycle under continuous tready.

Parameters:
DATA_WIDTH, 32, tdata width and pattern arithmetic width (modulo 2^DATA_WIDTH).
CNT_WIDTH, 12, width of the x/y counters and of cfg_width/cfg_height.
FCNT_WIDTH, 16, width of the frame_count status counter.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle frame request; sampled only in IDLE.
cfg_width  in  CNT_WIDTH  beats per line; latched on accepted start.
cfg_height  in  CNT_WIDTH  lines per frame; latched on accepted start.
cfg_mode  in  2  pattern select; latched on accepted start.
cfg_seed  in  DATA_WIDTH  pattern seed/constant; latched on accepted start.
busy  out  1  high from the cycle after an accepted start until the cycle frame_done is asserted (exclusive).
frame_done  out  1  one-cycle pulse at frame completion.
frame_count  out  FCNT_WIDTH  completed frames; wraps modulo 2^FCNT_WIDTH.
m_axis_tdata  out  DATA_WIDTH  pixel data.
m_axis_tvalid  out  1  beat valid.
m_axis_tready  in  1  downstream ready.
m_axis_tlast  out  1  last beat of a line.
m_axis_tuser  out  1  first beat of a frame (SOF).

Behaviour:
- Reset: state IDLE. tvalid, tlast, tuser, busy, frame_done = 0. frame_count = 0. tdata = 0. x, y and the beat index = 0.
- FSM states:
  - IDLE: on start=1, latch cfg_*, set busy. If the latched width==0 or height==0, go to DONE. Otherwise load beat 0 and go to RUN; tvalid=1 the next cycle (latency 1 from start).
  - RUN: a transfer occurs when tvalid && tready.
    - Non-final beat transferred: load the next beat into the output registers in the same edge (no bubble).
    - Final beat transferred (x==w-1, y==h-1): clear tvalid and go to DONE.
  - DONE: one cycle. Assert frame_done=1, busy=0, frame_count+1, then return to IDLE.
- Handshake rules:
  - tvalid never depends combinationally on tready.
  - While tvalid && !tready, tdata/tlast/tuser are held stable.
  - tvalid never drops before its beat is transferred.
- Counters:
  - x increments per transferred beat; it wraps to 0 after w-1, and y increments on that wrap.
  - idx is the frame beat index (DATA_WIDTH wide), reset to 0 per frame.
- Sideband flags:
  - tuser=1 only on the beat with x==0, y==0.
  - tlast=1 exactly when x==w-1.
- Pattern (DATA_WIDTH arithmetic, truncation/zero-extension):
  - mode 0: seed+idx.
  - mode 1: (y<<CNT_WIDTH)|x.
  - mode 2: constant seed.
  - mode 3: zero-extended x^y.
- start timing:
  - start in RUN or DONE is ignored (no queueing).
  - start in the cycle frame_done is high: the FSM is already in IDLE, so start is accepted and the new frame's tvalid rises 1 cycle later.
- Config inputs may change freely after an accepted start; the latched values govern the whole frame.
- Zero-size frame: no beat is ever valid. frame_done pulses 1 cycle after start, and frame_count increments.
- Reset mid-frame: tvalid=0 after the reset edge, no frame_done, frame_count=0, partial frame abandoned.
- Max frame: w=h=2^CNT_WIDTH-1. The y wrap after the final line is never reached because RUN exits first.

Test Plan:
1. w=4, h=2, mode 0, seed=0x10, tready=1 -> 8 consecutive beats with tdata 0x10..0x17; tuser on beat 0 only; tlast on beats 3 and 7; frame_done 1 cycle after beat 7; frame_count=1.
2. w=3, h=2, mode 1, CNT_WIDTH=12 -> tdata 0x000, 0x001, 0x002, 0x1000, 0x1001, 0x1002; tlast on beats 2 and 5.
3. Test 1 config with random tready (~50%) -> identical beat sequence; outputs stable whenever tvalid && !tready; no beats lost or duplicated.
4. w=0, h=5, start -> tvalid stays 0; frame_done 1 cycle after start; busy 0; frame_count increments.
5. start pulsed mid-frame -> ignored, exactly w*h beats sent. start in the frame_done cycle -> second frame's tvalid 1 cycle later; frame_count=2 at the end.
6. w=8, h=8, rst asserted after 3 transfers -> tvalid=0 and busy=0 next cycle; frame_done never pulses; frame_count=0; a new start yields a full frame beginning with tuser=1.
